// File: rtl/reduce_pkg.sv
// Shared op encodings and tree-sizing helpers for the reduce_pipe reduction unit.
package reduce_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_OR  = 2'b00;
    localparam op_t OP_AND = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_NOR = 2'b11;

    // Padding value that leaves a node's result unchanged for the given op.
    function automatic logic op_identity(input op_t op);
        return (op == OP_AND);
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned ceil_log(input int unsigned width, input int unsigned fanin);
        int unsigned n;
        int unsigned span;
        n    = 0;
        span = 1;
        while (span < width) begin
            span = span * fanin;
            n    = n + 1;
        end
        return n;
    endfunction

    // Width of tree level k; level 0 is the operand itself.
    function automatic int unsigned level_width(input int unsigned width,
                                                input int unsigned fanin,
                                                input int unsigned k);
        int unsigned w;
        w = width;
        for (int unsigned i = 0; i < k; i++) begin
            w = ceil_div(w, fanin);
        end
        return w;
    endfunction

    // Bit offset of level k in a flat bus holding levels 0, 1, 2, ... back to back.
    function automatic int unsigned level_offset(input int unsigned width,
                                                 input int unsigned fanin,
                                                 input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < k; i++) begin
            off = off + level_width(width, fanin, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/reduce_level.sv
// One level of the reduction tree: identity padding, FANIN-ary combine per node,
// and a registered stage with valid/advance handshake.
module reduce_level
    import reduce_pkg::*;
#(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned FANIN = 8,
    localparam int unsigned OUT_W = ceil_div(IN_W, FANIN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  op_t              in_op,
    input  logic             next_adv,
    output logic             adv,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output op_t              out_op
);

    localparam int unsigned PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] node;
    logic             valid_q;
    logic [OUT_W-1:0] data_q;
    op_t              op_q;

    // NOR reduces as OR here; the inversion is applied once after the last level.
    function automatic logic combine(input op_t op, input logic [FANIN-1:0] grp);
        unique case (op)
            OP_AND:  return &grp;
            OP_XOR:  return ^grp;
            default: return |grp;
        endcase
    endfunction

    always_comb begin
        padded           = {PAD_W{op_identity(in_op)}};
        padded[IN_W-1:0] = in_data;
        node             = '0;
        for (int n = 0; n < OUT_W; n++) begin
            node[n] = combine(in_op, padded[n*FANIN +: FANIN]);
        end
    end

    assign adv = !valid_q || next_adv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= OP_OR;
        end else if (adv) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= node;
                op_q   <= in_op;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;

endmodule

// File: rtl/reduce_pipe.sv
// Pipelined WIDTH-bit OR/AND/XOR/NOR reducer built from LEVELS reduce_level stages.
// Define REDUCE_PIPE_STATS_EN to add delivered-result counters (stat_txn, stat_ones).
module reduce_pipe
    import reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FANIN = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  op_t              in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
`ifdef REDUCE_PIPE_STATS_EN
    input  logic             stat_clear,
    output logic [31:0]      stat_txn,
    output logic [31:0]      stat_ones,
`endif
    output op_t              out_op
);

    localparam int unsigned LEVELS = ceil_log(WIDTH, FANIN);
    localparam int unsigned BUS_W  = level_offset(WIDTH, FANIN, LEVELS + 1);

    logic [BUS_W-1:0] bus;
    logic             ready_q;
    logic             accept;
    logic             last_adv;

    // Keeps in_ready low during reset and until the first edge after release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign bus[WIDTH-1:0] = in_data;
    assign accept         = in_valid && in_ready;
    assign last_adv       = !out_valid || out_ready;

    for (genvar g = 0; g < LEVELS; g++) begin : g_level
        localparam int unsigned IN_W  = level_width(WIDTH, FANIN, g);
        localparam int unsigned IN_O  = level_offset(WIDTH, FANIN, g);
        localparam int unsigned OUT_W = level_width(WIDTH, FANIN, g + 1);
        localparam int unsigned OUT_O = level_offset(WIDTH, FANIN, g + 1);

        logic prev_valid;
        op_t  prev_op;
        logic next_adv;
        logic adv;
        logic valid;
        op_t  op;

        if (g == 0) begin : g_first
            assign prev_valid = accept;
            assign prev_op    = in_op;
        end else begin : g_inner
            assign prev_valid = g_level[g-1].valid;
            assign prev_op    = g_level[g-1].op;
        end

        if (g == LEVELS - 1) begin : g_tail
            assign next_adv = last_adv;
        end else begin : g_body
            assign next_adv = g_level[g+1].adv;
        end

        reduce_level #(
            .IN_W  (IN_W),
            .FANIN (FANIN)
        ) u_level (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (prev_valid),
            .in_data   (bus[IN_O +: IN_W]),
            .in_op     (prev_op),
            .next_adv  (next_adv),
            .adv       (adv),
            .out_valid (valid),
            .out_data  (bus[OUT_O +: OUT_W]),
            .out_op    (op)
        );
    end

    assign in_ready  = ready_q && g_level[0].adv;
    assign out_valid = g_level[LEVELS-1].valid;
    assign out_op    = g_level[LEVELS-1].op;
    assign out_bit   = bus[BUS_W-1] ^ (out_op == OP_NOR);

`ifdef REDUCE_PIPE_STATS_EN
    logic [31:0] txn_q;
    logic [31:0] ones_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txn_q  <= '0;
            ones_q <= '0;
        end else if (stat_clear) begin
            txn_q  <= '0;
            ones_q <= '0;
        end else if (out_valid && out_ready) begin
            txn_q <= txn_q + 32'd1;
            if (out_bit) begin
                ones_q <= ones_q + 32'd1;
            end
        end
    end

    assign stat_txn  = txn_q;
    assign stat_ones = ones_q;
`endif

endmodule

// File: tb/tb_reduce_pipe.sv
// Directed bench for reduce_pipe: default 32/8 instance plus a 35/4 instance for padding.
module tb_reduce_pipe;
    import reduce_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [34:0] data;
        logic        res;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        i0_valid = 1'b0;
    logic        i0_ready;
    logic [31:0] i0_data  = '0;
    logic [1:0]  i0_op    = 2'b00;
    logic        o0_valid;
    logic        o0_ready = 1'b1;
    logic        o0_bit;
    logic [1:0]  o0_op;

    logic        i1_valid = 1'b0;
    logic        i1_ready;
    logic [34:0] i1_data  = '0;
    logic [1:0]  i1_op    = 2'b00;
    logic        o1_valid;
    logic        o1_ready = 1'b1;
    logic        o1_bit;
    logic [1:0]  o1_op;

`ifdef REDUCE_PIPE_STATS_EN
    logic        s0_clear = 1'b0;
    logic [31:0] s0_txn;
    logic [31:0] s0_ones;
    logic        s1_clear = 1'b0;
    logic [31:0] s1_txn;
    logic [31:0] s1_ones;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    reduce_pipe u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (i0_valid),
        .in_ready  (i0_ready),
        .in_data   (i0_data),
        .in_op     (i0_op),
        .out_valid (o0_valid),
        .out_ready (o0_ready),
        .out_bit   (o0_bit),
`ifdef REDUCE_PIPE_STATS_EN
        .stat_clear(s0_clear),
        .stat_txn  (s0_txn),
        .stat_ones (s0_ones),
`endif
        .out_op    (o0_op)
    );

    reduce_pipe #(
        .WIDTH (35),
        .FANIN (4)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (i1_valid),
        .in_ready  (i1_ready),
        .in_data   (i1_data),
        .in_op     (i1_op),
        .out_valid (o1_valid),
        .out_ready (o1_ready),
        .out_bit   (o1_bit),
`ifdef REDUCE_PIPE_STATS_EN
        .stat_clear(s1_clear),
        .stat_txn  (s1_txn),
        .stat_ones (s1_ones),
`endif
        .out_op    (o1_op)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit wide, input logic v, input logic [1:0] op,
                         input logic [34:0] d);
        if (wide) begin
            i1_valid = v;
            i1_op    = op;
            i1_data  = d;
        end else begin
            i0_valid = v;
            i0_op    = op;
            i0_data  = d[31:0];
        end
    endtask

    // Streams tbl back to back with out_ready high; an operand presented after
    // edge t must appear at the output after edge t+lat.
    task automatic run_table(input bit wide, input int lat, input string tag);
        int n;
        int j;
        n = tbl.size();
        for (int i = 0; i < n + lat; i++) begin
            j = i - lat + 1;
            if (i < n) begin
                drive(wide, 1'b1, tbl[i].op, tbl[i].data);
                check($sformatf("%s[%0d] in_ready", tag, i), wide ? i1_ready : i0_ready, 1);
            end else begin
                drive(wide, 1'b0, 2'b00, '0);
            end
            tick();
            if (j >= 0 && j < n) begin
                check($sformatf("%s[%0d] out_valid", tag, j), wide ? o1_valid : o0_valid, 1);
                check($sformatf("%s[%0d] out_bit", tag, j), wide ? o1_bit : o0_bit, tbl[j].res);
                check($sformatf("%s[%0d] out_op", tag, j), wide ? o1_op : o0_op, tbl[j].op);
            end else begin
                check($sformatf("%s idle out_valid @%0d", tag, i), wide ? o1_valid : o0_valid, 0);
            end
        end
    endtask

    vec_t main_v[12] = '{
        '{OP_OR,  35'h0_0000_0000, 1'b0},
        '{OP_OR,  35'h0_0001_0000, 1'b1},
        '{OP_NOR, 35'h0_0000_0000, 1'b1},
        '{OP_NOR, 35'h0_8000_0000, 1'b0},
        '{OP_AND, 35'h0_FFFF_FFFF, 1'b1},
        '{OP_AND, 35'h0_FFFF_FFFE, 1'b0},
        '{OP_XOR, 35'h0_0000_0007, 1'b1},
        '{OP_XOR, 35'h0_8000_0001, 1'b0},
        '{OP_OR,  35'h0_8000_0000, 1'b1},
        '{OP_NOR, 35'h0_0000_0100, 1'b0},
        '{OP_AND, 35'h0_7FFF_FFFF, 1'b0},
        '{OP_XOR, 35'h0_1000_0000, 1'b1}
    };

    vec_t wide_v[8] = '{
        '{OP_AND, 35'h7_FFFF_FFFF, 1'b1},
        '{OP_XOR, 35'h4_0000_0001, 1'b0},
        '{OP_XOR, 35'h4_0000_0000, 1'b1},
        '{OP_OR,  35'h0_0000_0000, 1'b0},
        '{OP_NOR, 35'h4_0000_0000, 1'b0},
        '{OP_AND, 35'h3_FFFF_FFFF, 1'b0},
        '{OP_NOR, 35'h0_0000_0000, 1'b1},
        '{OP_OR,  35'h4_0000_0000, 1'b1}
    };

    vec_t bp_v[6] = '{
        '{OP_OR,  35'h0_0000_0000, 1'b0},
        '{OP_AND, 35'h0_FFFF_FFFF, 1'b1},
        '{OP_XOR, 35'h0_0000_0003, 1'b0},
        '{OP_NOR, 35'h0_0000_0000, 1'b1},
        '{OP_XOR, 35'h0_0000_0001, 1'b1},
        '{OP_NOR, 35'h0_0000_0010, 1'b0}
    };

    vec_t stat_v[10] = '{
        '{OP_OR,  35'h0_0000_0000, 1'b0},
        '{OP_OR,  35'h0_0000_0001, 1'b1},
        '{OP_AND, 35'h0_0000_0000, 1'b0},
        '{OP_XOR, 35'h0_0000_0003, 1'b0},
        '{OP_NOR, 35'h0_0000_0001, 1'b0},
        '{OP_NOR, 35'h0_0000_0000, 1'b1},
        '{OP_AND, 35'h0_FFFF_FFFF, 1'b1},
        '{OP_XOR, 35'h0_0000_0000, 1'b0},
        '{OP_OR,  35'h0_0000_0000, 1'b0},
        '{OP_AND, 35'h0_FFFF_0000, 1'b0}
    };

    initial begin
        vec_t       exp_q[$];
        int         sent;
        int         got;
        logic       prev_stall;
        logic       prev_bit;
        logic [1:0] prev_op;
        logic       saw_block;

        // Reset state, sampled mid-cycle with reset still high.
        #12;
        check("reset out_valid", o0_valid, 0);
        check("reset out_bit", o0_bit, 0);
        check("reset out_op", o0_op, 0);
        check("reset in_ready", i0_ready, 0);
        check("reset wide out_valid", o1_valid, 0);
        check("reset wide in_ready", i1_ready, 0);
        reset = 1'b0;
        #1;
        check("released, pre-edge in_ready", i0_ready, 0);
        tick();
        check("post-release in_ready", i0_ready, 1);
        check("post-release wide in_ready", i1_ready, 1);

        tbl.delete();
        foreach (main_v[k]) tbl.push_back(main_v[k]);
        run_table(1'b0, 2, "main");

        tbl.delete();
        foreach (wide_v[k]) tbl.push_back(wide_v[k]);
        run_table(1'b1, 3, "wide");

        // Backpressure: out_ready low for cycles 3..6 while 6 operands stream in.
        tbl.delete();
        foreach (bp_v[k]) tbl.push_back(bp_v[k]);
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        prev_op    = 2'b00;
        saw_block  = 1'b0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            o0_ready = !(c >= 3 && c < 7);
            if (sent < 6) drive(1'b0, 1'b1, tbl[sent].op, tbl[sent].data);
            else          drive(1'b0, 1'b0, 2'b00, '0);
            #1;
            if (prev_stall) begin
                check($sformatf("bp stall hold bit @%0d", c), o0_bit, prev_bit);
                check($sformatf("bp stall hold op @%0d", c), o0_op, prev_op);
            end
            if (i0_valid && !i0_ready) saw_block = 1'b1;
            if (o0_valid && o0_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("bp unexpected result @%0d", c), o0_valid, 0);
                end else begin
                    check($sformatf("bp[%0d] out_bit", got), o0_bit, exp_q[0].res);
                    check($sformatf("bp[%0d] out_op", got), o0_op, exp_q[0].op);
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (i0_valid && i0_ready) begin
                exp_q.push_back(tbl[sent]);
                sent++;
            end
            prev_stall = o0_valid && !o0_ready;
            prev_bit   = o0_bit;
            prev_op    = o0_op;
            tick();
        end
        drive(1'b0, 1'b0, 2'b00, '0);
        o0_ready = 1'b1;
        check("bp results delivered", got, 6);
        check("bp in_ready fell while stalled", saw_block, 1);
        tick();
        tick();
        check("bp no duplicate out_valid", o0_valid, 0);

        // Reset with two operands in flight.
        drive(1'b0, 1'b1, OP_AND, 35'h0_FFFF_FFFF);
        tick();
        drive(1'b0, 1'b1, OP_NOR, 35'h0_0000_0000);
        tick();
        drive(1'b0, 1'b0, 2'b00, '0);
        check("rst in-flight out_valid", o0_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst async out_valid", o0_valid, 0);
        check("rst async out_bit", o0_bit, 0);
        check("rst async in_ready", i0_ready, 0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("rst release pre-edge in_ready", i0_ready, 0);
        tick();
        check("rst release in_ready", i0_ready, 1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst no stale out_valid @%0d", c), o0_valid, 0);
            tick();
        end
        tbl.delete();
        tbl.push_back('{OP_OR, 35'h0_0001_0000, 1'b1});
        run_table(1'b0, 2, "post_rst");

`ifdef REDUCE_PIPE_STATS_EN
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        tbl.delete();
        foreach (stat_v[k]) tbl.push_back(stat_v[k]);
        run_table(1'b0, 2, "stats");
        check("stat_txn", s0_txn, 10);
        check("stat_ones", s0_ones, 3);
        s0_clear = 1'b1;
        tick();
        s0_clear = 1'b0;
        check("stat_txn cleared", s0_txn, 0);
        check("stat_ones cleared", s0_ones, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
